// File: rtl/wb_pkg.sv
// Shared definitions for the Wishbone arbiter family: FSM encoding,
// watchdog counter sizing and the two-host round-robin pick.
package wb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        ABORT = 2'd2
    } state_e;

    localparam int unsigned WDC_MIN_W = 8;

    function automatic int unsigned wdc_width(input int unsigned timeout);
        int unsigned w;
        w = $clog2(timeout + 1);
        return (w < WDC_MIN_W) ? WDC_MIN_W : w;
    endfunction

    // Returns {valid, host}; a tie goes to the host that was not granted last.
    function automatic logic [1:0] rr_pick(input logic cyc0, input logic cyc1, input logic last);
        logic [1:0] p;
        p = 2'b00;
        if (cyc0 && cyc1) p = {1'b1, ~last};
        else if (cyc0)    p = 2'b10;
        else if (cyc1)    p = 2'b11;
        return p;
    endfunction

endpackage

// File: rtl/wbarb_2x1_if.sv
// Classic Wishbone port bundle; master drives the request, slave answers.
interface wbarb_2x1_if #(
    parameter int unsigned AW = 24,
    parameter int unsigned DW = 32,
    parameter int unsigned SW = DW / 8
);
    logic          cyc;
    logic          stb;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [SW-1:0] sel;
    logic          ack;
    logic          err;
    logic [DW-1:0] rdata;

    modport master (output cyc, stb, we, addr, wdata, sel, input ack, err, rdata);
    modport slave  (input cyc, stb, we, addr, wdata, sel, output ack, err, rdata);
endinterface

// File: rtl/wb_timeout.sv
// Bus watchdog: counts cycles a strobe waits without a response and flags
// the cycle in which the wait reaches TIMEOUT. TIMEOUT = 0 never expires.
module wb_timeout
    import wb_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic stb,
    input  logic resp,
    output logic expire
);
    localparam int unsigned CW = wdc_width(TIMEOUT);
    localparam logic [CW-1:0] LIMIT = CW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    logic [CW-1:0] wdc;

    // Saturating wait counter, cleared whenever the strobe is idle or answered
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wdc <= '0;
        end else if (!stb || resp) begin
            wdc <= '0;
        end else if (wdc != '1) begin
            wdc <= wdc + CW'(1);
        end
    end

    assign expire = (TIMEOUT != 0) && stb && !resp && (wdc == LIMIT);
endmodule

// File: rtl/wbarb_2x1.sv
// Two-host, one-device Wishbone arbiter: round-robin ownership per cyc
// cycle, combinational data path, and a watchdog that aborts hung accesses.
module wbarb_2x1
    import wb_pkg::*;
#(
    parameter int unsigned AW      = 24,
    parameter int unsigned DW      = 32,
    parameter int unsigned SW      = DW / 8,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    wbarb_2x1_if.slave  wb_host0,
    wbarb_2x1_if.slave  wb_host1,
    wbarb_2x1_if.master wb_dev,
    output logic [1:0]  grant,
    output logic        timeout_evt
);
    state_e        state, state_nxt;
    logic          owner, owner_nxt;
    logic          last, last_nxt;
    logic [1:0]    pick;
    logic          rearb, expire, resp;
    logic          own_cyc, own_stb, own_we;
    logic [AW-1:0] own_addr;
    logic [DW-1:0] own_wdata;
    logic [SW-1:0] own_sel;
    logic          m_cyc, m_stb, m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [SW-1:0] m_sel;
    logic          ack0, ack1, err0, err1;

    assign resp      = wb_dev.ack | wb_dev.err;
    assign pick      = rr_pick(wb_host0.cyc, wb_host1.cyc, last);
    assign own_cyc   = owner ? wb_host1.cyc   : wb_host0.cyc;
    assign own_stb   = owner ? wb_host1.stb   : wb_host0.stb;
    assign own_we    = owner ? wb_host1.we    : wb_host0.we;
    assign own_addr  = owner ? wb_host1.addr  : wb_host0.addr;
    assign own_wdata = owner ? wb_host1.wdata : wb_host0.wdata;
    assign own_sel   = owner ? wb_host1.sel   : wb_host0.sel;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            owner <= 1'b0;
            last  <= 1'b1;
        end else begin
            state <= state_nxt;
            owner <= owner_nxt;
            last  <= last_nxt;
        end
    end

    // Re-arbitrate when idle or on the edge the owner releases cyc
    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        last_nxt  = last;
        rearb     = (state == IDLE) || ((state == BUSY) && !own_cyc);
        if (rearb) begin
            state_nxt = pick[1] ? BUSY : IDLE;
            if (pick[1]) begin
                owner_nxt = pick[0];
                last_nxt  = pick[0];
            end
        end else if ((state == BUSY) && expire) begin
            state_nxt = ABORT;
        end else if (state == ABORT) begin
            state_nxt = IDLE;
            last_nxt  = owner;
        end
    end

    always_comb begin
        m_cyc       = 1'b0;
        m_stb       = 1'b0;
        m_we        = 1'b0;
        m_addr      = '0;
        m_wdata     = '0;
        m_sel       = '0;
        ack0        = 1'b0;
        ack1        = 1'b0;
        err0        = 1'b0;
        err1        = 1'b0;
        grant       = 2'b00;
        timeout_evt = 1'b0;
        case (state)
            BUSY: begin
                m_cyc   = own_cyc;
                m_stb   = own_stb;
                m_we    = own_we;
                m_addr  = own_addr;
                m_wdata = own_wdata;
                m_sel   = own_sel;
                grant   = owner ? 2'b10 : 2'b01;
                ack0    = !owner && wb_host0.cyc && wb_dev.ack;
                ack1    =  owner && wb_host1.cyc && wb_dev.ack;
                err0    = !owner && wb_host0.cyc && wb_dev.err;
                err1    =  owner && wb_host1.cyc && wb_dev.err;
            end
            // Device is released and any late response is dropped
            ABORT: begin
                timeout_evt = 1'b1;
                err0        = !owner;
                err1        = owner;
            end
            default: ;
        endcase
    end

    assign wb_dev.cyc     = m_cyc;
    assign wb_dev.stb     = m_stb;
    assign wb_dev.we      = m_we;
    assign wb_dev.addr    = m_addr;
    assign wb_dev.wdata   = m_wdata;
    assign wb_dev.sel     = m_sel;
    assign wb_host0.ack   = ack0;
    assign wb_host1.ack   = ack1;
    assign wb_host0.err   = err0;
    assign wb_host1.err   = err1;
    assign wb_host0.rdata = wb_dev.rdata;
    assign wb_host1.rdata = wb_dev.rdata;

    wb_timeout #(.TIMEOUT(TIMEOUT)) u_wdt (
        .clk    (clk),
        .rst    (rst),
        .stb    (m_stb),
        .resp   (resp),
        .expire (expire)
    );
endmodule

// File: tb/tb_wbarb_2x1.sv
// Bench for wbarb_2x1: directed vector table, hand-written corner sequences
// and a randomized run against a cycle-level model of the arbitration rules.
module tb_wbarb_2x1;
    localparam int unsigned AW = 24;
    localparam int unsigned DW = 32;
    localparam int unsigned SW = 4;
    localparam int TO = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    wbarb_2x1_if #(.AW(AW), .DW(DW), .SW(SW)) h0 ();
    wbarb_2x1_if #(.AW(AW), .DW(DW), .SW(SW)) h1 ();
    wbarb_2x1_if #(.AW(AW), .DW(DW), .SW(SW)) dv ();
    wbarb_2x1_if #(.AW(AW), .DW(DW), .SW(SW)) z0 ();
    wbarb_2x1_if #(.AW(AW), .DW(DW), .SW(SW)) z1 ();
    wbarb_2x1_if #(.AW(AW), .DW(DW), .SW(SW)) zd ();
    logic [1:0] grant, zgrant;
    logic       evt, zevt;

    wbarb_2x1 #(.AW(AW), .DW(DW), .SW(SW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .wb_host0(h0), .wb_host1(h1), .wb_dev(dv),
        .grant(grant), .timeout_evt(evt));

    // Watchdog-disabled copy sees the same host and device stimulus
    wbarb_2x1 #(.AW(AW), .DW(DW), .SW(SW), .TIMEOUT(0)) dut_nt (
        .clk(clk), .rst(rst), .wb_host0(z0), .wb_host1(z1), .wb_dev(zd),
        .grant(zgrant), .timeout_evt(zevt));

    assign z0.cyc = h0.cyc;   assign z0.stb = h0.stb;     assign z0.we = h0.we;
    assign z0.addr = h0.addr; assign z0.wdata = h0.wdata; assign z0.sel = h0.sel;
    assign z1.cyc = h1.cyc;   assign z1.stb = h1.stb;     assign z1.we = h1.we;
    assign z1.addr = h1.addr; assign z1.wdata = h1.wdata; assign z1.sel = h1.sel;
    assign zd.ack = dv.ack;   assign zd.err = dv.err;     assign zd.rdata = dv.rdata;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [3:0]  in;   // {cyc0, cyc1, dev_ack, dev_err}; stb follows cyc
        logic [7:0]  out;  // {grant[1:0], dev_cyc, ack0, ack1, err0, err1, timeout_evt}
        logic [23:0] addr; // expected dev_addr
    } row_t;
    row_t rows[17];

    logic m_own, m_who, m_last, m_abort;
    int   m_run;

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic c0, input logic s0, input logic c1, input logic s1,
                         input logic da, input logic de);
        h0.cyc = c0; h0.stb = s0; h1.cyc = c1; h1.stb = s1; dv.ack = da; dv.err = de;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        tick();
        @(negedge clk);
        rst = 1'b1;
        tick();
    endtask

    function automatic logic [31:0] tvec();
        return {grant, dv.cyc, h0.ack, h1.ack, h0.err, h1.err, evt, dv.addr};
    endfunction

    function automatic logic [159:0] dut_out();
        return 160'({grant, evt, h0.ack, h1.ack, h0.err, h1.err, dv.cyc, dv.stb, dv.we,
                     dv.addr, dv.wdata, dv.sel, h0.rdata, h1.rdata});
    endfunction

    // What the outputs must be this cycle, given who holds the bus
    function automatic logic [159:0] model_out();
        logic [1:0]  g;
        logic        a0, a1, e0, e1, ev, dc, ds, dw;
        logic [23:0] da;
        logic [31:0] dd;
        logic [3:0]  dsl;
        g = 2'b00; {a0, a1, e0, e1, ev, dc, ds, dw} = 8'h00; da = '0; dd = '0; dsl = '0;
        if (m_abort) begin
            ev = 1'b1; e0 = !m_who; e1 = m_who;
        end else if (m_own && !m_who) begin
            g = 2'b01;
            {dc, ds, dw, da, dd, dsl} = {h0.cyc, h0.stb, h0.we, h0.addr, h0.wdata, h0.sel};
            a0 = h0.cyc & dv.ack; e0 = h0.cyc & dv.err;
        end else if (m_own) begin
            g = 2'b10;
            {dc, ds, dw, da, dd, dsl} = {h1.cyc, h1.stb, h1.we, h1.addr, h1.wdata, h1.sel};
            a1 = h1.cyc & dv.ack; e1 = h1.cyc & dv.err;
        end
        return 160'({g, ev, a0, a1, e0, e1, dc, ds, dw, da, dd, dsl, dv.rdata, dv.rdata});
    endfunction

    // Ownership bookkeeping at a clock edge; m_run is the current unanswered-strobe run length
    task automatic model_step();
        logic o_cyc, o_stb, resp;
        o_cyc = m_who ? h1.cyc : h0.cyc;
        o_stb = m_who ? h1.stb : h0.stb;
        resp  = dv.ack | dv.err;
        if (m_abort) begin
            m_abort = 1'b0; m_own = 1'b0; m_last = m_who; m_run = 0;
        end else if (m_own && o_cyc) begin
            m_run = (o_stb && !resp) ? m_run + 1 : 0;
            if (m_run == TO) begin
                m_abort = 1'b1; m_run = 0;
            end
        end else begin
            m_run = 0;
            m_own = h0.cyc | h1.cyc;
            if (m_own) begin
                m_who  = (h0.cyc && h1.cyc) ? !m_last : h1.cyc;
                m_last = m_who;
            end
        end
    endtask

    task automatic rand_inputs();
        if ($urandom_range(7) == 0) h0.cyc = ~h0.cyc;
        if ($urandom_range(7) == 0) h1.cyc = ~h1.cyc;
        h0.stb = h0.cyc && ($urandom_range(15) != 0);
        h1.stb = h1.cyc && ($urandom_range(15) != 0);
        h0.we = 1'($urandom); h0.addr = 24'($urandom); h0.wdata = $urandom; h0.sel = 4'($urandom);
        h1.we = 1'($urandom); h1.addr = 24'($urandom); h1.wdata = $urandom; h1.sel = 4'($urandom);
        dv.ack = ($urandom_range(7) == 0);
        dv.err = ($urandom_range(31) == 0);
        dv.rdata = $urandom;
    endtask

    initial begin
        int bad;
        rows[0]  = '{4'b1000, 8'b00_0_0000_0, 24'h0};
        rows[1]  = '{4'b1000, 8'b01_1_0000_0, 24'h10};
        rows[2]  = '{4'b1000, 8'b01_1_0000_0, 24'h10};
        rows[3]  = '{4'b1010, 8'b01_1_1000_0, 24'h10};
        rows[4]  = '{4'b0000, 8'b01_0_0000_0, 24'h10};
        rows[5]  = '{4'b0000, 8'b00_0_0000_0, 24'h0};
        rows[6]  = '{4'b1100, 8'b00_0_0000_0, 24'h0};
        rows[7]  = '{4'b1100, 8'b10_1_0000_0, 24'h20};
        rows[8]  = '{4'b1110, 8'b10_1_0100_0, 24'h20};
        rows[9]  = '{4'b1000, 8'b10_0_0000_0, 24'h20};
        rows[10] = '{4'b1000, 8'b01_1_0000_0, 24'h10};
        rows[11] = '{4'b1010, 8'b01_1_1000_0, 24'h10};
        rows[12] = '{4'b0100, 8'b01_0_0000_0, 24'h10};
        rows[13] = '{4'b0100, 8'b10_1_0000_0, 24'h20};
        rows[14] = '{4'b0101, 8'b10_1_0001_0, 24'h20};
        rows[15] = '{4'b0000, 8'b10_0_0000_0, 24'h20};
        rows[16] = '{4'b0000, 8'b00_0_0000_0, 24'h0};

        h0.we = 1'b1; h0.addr = 24'h000010; h0.wdata = 32'hDEADBEEF; h0.sel = 4'hF;
        h1.we = 1'b0; h1.addr = 24'h000020; h1.wdata = 32'h12345678; h1.sel = 4'h3;
        dv.rdata = 32'hCAFEF00D;

        // Reset held with both hosts requesting and a stray device ack
        drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        tick(); tick();
        chk("reset", 160'({tvec(), dv.stb}), 160'(0));
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        tick();

        for (int i = 0; i < 17; i++) begin
            drive(rows[i].in[3], rows[i].in[3], rows[i].in[2], rows[i].in[2], rows[i].in[1], rows[i].in[0]);
            @(negedge clk);
            chk($sformatf("row%0d", i), 160'(tvec()), 160'({rows[i].out, rows[i].addr}));
            tick();
        end

        // Device never answers host0; host1 waits and wins after the abort
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        for (int k = 0; k < 8; k++) begin
            drive(1'b1, 1'b1, k >= 1, k >= 1, 1'b0, 1'b0);
            @(negedge clk);
            chk($sformatf("to_wait%0d", k), 160'({h0.err, evt, dv.stb}), 160'(3'b001));
            tick();
        end
        drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        chk("to_abort", 160'({h0.err, evt, dv.cyc, dv.stb, h0.ack, h1.ack, grant}), 160'(8'b1100_0000));
        tick();
        drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        chk("to_idle", 160'({grant, evt, h0.err}), 160'(0));
        tick();
        drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        chk("to_next_owner", 160'(grant), 160'(2'b10));
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(); tick();

        // Ack lands in the last cycle before the limit: it wins
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            chk($sformatf("ack8_wait%0d", k), 160'({h0.ack, h0.err, evt}), 160'(0));
            tick();
        end
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        chk("ack8_resp", 160'({h0.ack, h0.err, evt}), 160'(3'b100));
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("ack8_after", 160'({grant, evt, h0.err}), 160'(4'b0100));
        tick(); tick();

        // Asynchronous reset while host1 owns the bus and the device is acking
        drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        #1;
        chk("pre_rst", 160'({grant, h1.ack}), 160'(3'b101));
        rst = 1'b0;
        #1;
        chk("rst_mid", 160'({tvec(), dv.stb}), 160'(0));
        drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_idle", 160'(grant), 160'(0));
        tick();
        chk("rst_tie", 160'(grant), 160'(2'b01));
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(); tick();

        // Watchdog disabled: a 1000-cycle stall is never aborted
        do_reset();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        bad = 0;
        for (int k = 0; k < 1000; k++) begin
            @(negedge clk);
            if (z0.err || z0.ack || zevt || !zd.stb || !zd.cyc) bad++;
            tick();
        end
        chk("nt_stall_bad_cycles", 160'(bad), 160'(0));
        chk("nt_grant", 160'(zgrant), 160'(2'b01));

        // Random traffic against the model
        do_reset();
        m_own = 1'b0; m_who = 1'b0; m_last = 1'b1; m_abort = 1'b0; m_run = 0;
        for (int k = 0; k < 3000; k++) begin
            rand_inputs();
            @(negedge clk);
            chk($sformatf("rand%0d", k), dut_out(), model_out());
            @(posedge clk);
            model_step();
            #1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/wbarb_2x1.md
# wbarb_2x1

Two-host, one-device Wishbone arbiter with a bus-timeout watchdog. It shares a single device port, such as the SPI flash or PSRAM controller behind one crossbar slot, between two hosts, for example the CPU data port and a DMA engine. Ownership is granted per `cyc` cycle using round-robin, and a hung device access is aborted with `err` after a programmable number of cycles.

## Interface
Parameters:
- `AW`, 24: device/host address width.
- `DW`, 32: data width.
- `SW`, DW/8: byte-select width.
- `TIMEOUT`, 255: cycles `dev_stb` may wait for `ack`/`err` before abort; 0 disables the watchdog.

Ports:
- `clk`, in, 1: sole clock.
- `rst`, in, 1: asynchronous, active-low reset.
- `wb_host{0,1}_cyc`, `_stb`, `_we`, in, 1 each: host requests.
- `wb_host{0,1}_addr`, in, AW; `_wdata`, in, DW; `_sel`, in, SW.
- `wb_host{0,1}_ack`, `_err`, out, 1 each.
- `wb_host{0,1}_rdata`, out, DW.
- `wb_dev_cyc`, `_stb`, `_we`, out, 1 each; `wb_dev_addr`, out, AW; `wb_dev_wdata`, out, DW; `wb_dev_sel`, out, SW.
- `wb_dev_ack`, `_err`, in, 1 each; `wb_dev_rdata`, in, DW.
- `grant`, out, 2: one-hot current owner, 0 when idle.
- `timeout_evt`, out, 1: one-cycle pulse when an abort fires.

## Operation
- Classic Wishbone. A host holds `stb` until it receives `ack` or `err`. Ownership lasts from grant until the owner deasserts `cyc`.
- State register values: `IDLE`, `BUSY`, `ABORT`. Supporting registers: `owner` (1 bit) and `last` (1 bit, last host granted).
- `IDLE`:
  - If exactly one `cyc` is high, grant that host.
  - If both are high, grant `!last`.
  - On grant: go to `BUSY`, set `owner` and `last`.
- `BUSY`:
  - Device outputs are a combinational mux of the owner's signals.
  - Owner `ack`/`err` = device `ack`/`err` AND owner `cyc`.
  - On the edge where the owner's `cyc` is sampled low, arbitrate exactly as in `IDLE` and go directly to `BUSY` (new owner) or to `IDLE`.
- Watchdog, 8-bit-or-wider counter `wdc`:
  - Cleared when `dev_stb` is low or when `dev_ack`/`dev_err` is high.
  - Otherwise increments, saturating.
  - When `wdc == TIMEOUT-1` and there is no `ack`/`err` this cycle, go to `ABORT`.
- `ABORT` (exactly one cycle):
  - `dev_cyc` and `dev_stb` are 0.
  - Owner `err` = 1, `timeout_evt` = 1.
  - Any device `ack`/`err` in this cycle is discarded.
  - Next state is `IDLE`, with `last = owner`, so a waiting other host wins.
- Non-owner `ack`/`err` are always 0.
- `rdata` of both hosts = `wb_dev_rdata` (broadcast).
- In `IDLE`, all device outputs are 0.
- Simultaneous events:
  - `ack` arrives in the same cycle the count reaches its limit: `ack` wins, no abort.
  - Owner drops `cyc` while the other host raises `cyc`: the other host is granted on the next cycle.

## Timing
- Reset values: state `IDLE`, `last` = 1 (host0 wins the first tie), `owner` = 0, `wdc` = 0. All outputs 0, `grant` = 2'b00.
- Reset is effective immediately and at any point mid-transfer, with no `ack`/`err` issued.
- Grant latency: host `cyc` is sampled high on edge N, and `dev_cyc` goes high in cycle N+1.
- Handover: owner `cyc` is low in cycle N (so `dev_cyc` = 0 in N), and the new owner drives the device in cycle N+1. There is no further dead cycle.
- Device response to host: combinational, 0 cycles.
- Abort timing: `stb` rises in cycle S with no response, and `err` is asserted in cycle S+TIMEOUT.
- `grant` reflects the registered owner and is 0 in `IDLE` and `ABORT`.

## Structure
- Shared package `wb_pkg`:
  - State encoding: `IDLE` = 2'd0, `BUSY` = 2'd1, `ABORT` = 2'd2.
  - Counter-width function: clog2(TIMEOUT+1).
- One sub-module: `wb_timeout`.
  - Ports: `clk`, `rst`, `stb`, `resp`, `expire`.
  - Implements the watchdog counter, reusable by other arbiters.
- Arbitration FSM and muxes live in `wbarb_2x1`.

## Test plan
- Host0-only write to addr 0x000010, data 0xDEADBEEF, device acks after 2 cycles:
  - `dev_cyc` rises one cycle after host0 `cyc`.
  - host0 `ack` asserted; host1 `ack` = 0; `grant` = 01.
- Both hosts raise `cyc` in the same cycle after reset:
  - host0 is granted first.
  - On host0 `cyc` drop, host1 is granted the next cycle.
  - In a repeat of both-at-once, host1 is granted first.
- Device never responds, TIMEOUT = 8:
  - host0 `err` and `timeout_evt` are high exactly 8 cycles after `stb`.
  - `dev_cyc` = 0 that cycle.
  - A late `dev_ack` is not forwarded.
- `dev_ack` arrives on the 8th cycle with TIMEOUT = 8: `ack` is passed through, no `err`, no `timeout_evt`.
- Reset asserted low mid-burst while host1 is owner:
  - All outputs 0 and `grant` = 00 immediately.
  - After release, a both-host tie goes to host0.
- TIMEOUT = 0, device stalls 1000 cycles: no abort, `stb` is held throughout.
